keystroke_uart_tx: RTL and testbench
====================================

Name: keystroke_uart_tx

Overview:
- Sits downstream of the debounced keyboard stage.
- Captures each new-key pulse (`keyReady` plus the byte presented with it) into a small FIFO.
- Serialises queued bytes, oldest first, onto a UART 8N1 line.
- Absorbs bursts of keystrokes that arrive faster than one UART frame time. The queue depth bounds the burst size.

Parameters:
- CLKS_PER_BIT, 1000: clock cycles per UART bit period. Must be >= 2.
- DEPTH, 8: FIFO entries. Power of two, >= 2.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- RST  input  1  synchronous reset, active-high
- keyByte  input  8  key byte, valid only while keyReady is high
- keyReady  input  1  single-cycle pulse marking keyByte as a new key
- txOut  output  1  UART serial line, idle high
- busy  output  1  high whenever the TX state machine is not in IDLE
- count  output  $clog2(DEPTH)+1  number of FIFO entries currently queued
- overflow  output  1  sticky flag: a key was dropped because the FIFO was full

Behaviour:
- Reset:
  - Synchronous; sampled on a clk rising edge with RST=1.
  - After that edge: txOut=1, busy=0, count=0, overflow=0, read/write pointers=0, bit counter=0, state=IDLE.
  - Applies mid-frame: the frame is abandoned, txOut=1 from the next cycle, queued bytes are discarded.
- FIFO write:
  - An edge with keyReady=1 and count<DEPTH stores keyByte at the write pointer.
  - The write pointer advances modulo DEPTH.
- FIFO full drop:
  - keyReady=1 with count==DEPTH and no pop in the same cycle: byte dropped, overflow set to 1.
  - overflow stays 1 until reset.
- Simultaneous write and pop in the same cycle:
  - Both happen; count is unchanged.
  - This holds even when full, so no overflow is raised.
- count behaviour:
  - Width $clog2(DEPTH)+1.
  - Never exceeds DEPTH and never underflows.
  - Pops occur only when count>0.
- TX state machine, states IDLE, START, DATA, STOP:
  - IDLE:
    - txOut=1.
    - If count>0: pop the head into the shift register, clear the bit counter, go to START next cycle.
    - The pop decision uses count as registered at the start of the cycle. A byte written in cycle K is first visible in cycle K+1.
  - START: txOut=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - txOut = shift register bit [index], LSB first.
    - Each bit is held CLKS_PER_BIT cycles.
    - After bit 7 completes, go to STOP.
  - STOP: txOut=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame timing:
  - One frame is 10*CLKS_PER_BIT cycles plus at least 1 IDLE cycle between consecutive frames.
- Latency:
  - keyReady sampled at edge K with the FIFO empty and the FSM in IDLE: pop occurs in cycle K+1.
  - txOut falls at edge K+2.
- busy is high from the first START cycle through the last STOP cycle.
- txOut is a registered output and must be glitch-free.
- The bit-period counter is width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, then wraps to 0.
- keyByte is ignored when keyReady=0.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DEPTH=8.
1. Reset: hold RST=1 for 3 edges while pulsing keyReady -> txOut=1, busy=0, count=0, overflow=0, no frame follows.
2. Single key: keyReady pulse with keyByte=0x41 -> txOut low for 4 cycles (start bit), then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4 cycles (stop); busy=1 for exactly 40 cycles; count returns to 0.
3. Burst: 10 consecutive keyReady pulses with bytes 0x01..0x0A -> count peaks at 8; overflow=1 after the 10th pulse; exactly 9 frames carrying 0x01..0x09 in order; 0x0A never sent.
4. Full plus simultaneous pop: fill the FIFO to 8 while a frame is in flight; pulse keyReady=0x55 in the exact IDLE cycle of the pop -> count stays 8, overflow stays 0, and 0x55 is later transmitted last.
5. Reset mid-frame: assert RST during DATA bit 3 of 0xA5 with 3 bytes queued -> txOut=1 and count=0 from the next cycle; no further frames until a new keyReady.
6. Edge data: keys 0x00 then 0xFF -> 8 low data bits, then 8 high data bits; each frame is framed by a low start bit and a high stop bit, with at least 1 idle-high cycle between frames.

Source files
------------

// File: rtl/keystroke_uart_tx_if.sv
// Key-capture / UART-line bundle between the keyboard stage and the TX serialiser.
// master drives keys in; slave (the serialiser) drives the line and status back.
interface keystroke_uart_tx_if #(
  parameter int DEPTH = 8
);
  logic [7:0]               keyByte;
  logic                     keyReady;
  logic                     txOut;
  logic                     busy;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output keyByte,
    output keyReady,
    input  txOut,
    input  busy,
    input  count,
    input  overflow
  );

  modport slave (
    input  keyByte,
    input  keyReady,
    output txOut,
    output busy,
    output count,
    output overflow
  );
endinterface

// File: rtl/keystroke_uart_tx.sv
// Queues key bytes from the debounced keyboard stage in a small FIFO and sends
// them oldest-first as UART 8N1 frames; txOut is registered one cycle behind the FSM state.
module keystroke_uart_tx #(
  parameter int CLKS_PER_BIT = 1000,
  parameter int DEPTH        = 8
) (
  input  logic              clk,
  input  logic              RST,
  keystroke_uart_tx_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [BW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [7:0]      fifo_mem [DEPTH];

  logic            push;
  logic            pop;
  logic            bit_done;

  assign bit_done = (clk_cnt_q == BIT_LAST);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a key then.
  always_comb begin
    pop  = (state_q == ST_IDLE) && (count_q != '0);
    push = bus.keyReady && ((count_q != FULL) || pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.keyByte;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (bus.keyReady && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_done ? '0 : clk_cnt_q + BW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (pop) begin
          shift_d   = fifo_mem[rd_ptr_q];
          bit_idx_d = 3'd0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  // Line level follows the current state, so each bit appears one cycle after its state begins.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[bit_idx_q];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      clk_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.txOut    = tx_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_keystroke_uart_tx.sv
// Directed stimulus for keystroke_uart_tx with a line-decoding monitor that
// checks each received frame against a queue of expected bytes.
module tb_keystroke_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic RST = 1'b1;

  always #5 clk = ~clk;

  keystroke_uart_tx_if #(.DEPTH(DEPTH)) bus ();

  keystroke_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];

  bit         mon_active  = 1'b0;
  int         mon_cyc     = 0;
  int         gap         = 0;
  bit         gap_valid   = 1'b0;
  int         frames_seen = 0;
  logic [7:0] head        = 8'h00;
  logic [7:0] rx_byte     = 8'h00;
  bit         has_head    = 1'b0;
  bit         shape_ok    = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_key(input logic [7:0] b, input bit expect_tx);
    @(posedge clk); #1;
    bus.keyByte  = b;
    bus.keyReady = 1'b1;
    if (expect_tx) exp_q.push_back(b);
    @(posedge clk); #1;
    bus.keyReady = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    RST = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    RST = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && !mon_active && bus.busy == 1'b0) && k < max_cyc) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_drain_timeout"}, 32'(k >= max_cyc), 32'd0);
  endtask

  // Frame monitor: cycle 0 is the first low cycle; bits are checked every cycle
  // against the expected head byte and also sampled mid-bit to rebuild the byte.
  initial begin : monitor
    logic       exp_bit;
    logic [2:0] bi;
    forever begin
      @(negedge clk);
      if (RST) begin
        mon_active = 1'b0;
        gap_valid  = 1'b0;
        gap        = 0;
      end else begin
        if (!mon_active) begin
          if (bus.txOut == 1'b0) begin
            mon_active = 1'b1;
            mon_cyc    = 0;
            shape_ok   = 1'b1;
            rx_byte    = 8'h00;
            if (gap_valid) check("idle_gap_between_frames", 32'(gap >= 1), 32'd1);
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_frame: got start bit expected idle line");
              has_head = 1'b0;
              head     = 8'h00;
            end else begin
              has_head = 1'b1;
              head     = exp_q[0];
            end
          end else begin
            gap++;
          end
        end else begin
          mon_cyc++;
        end

        if (mon_active) begin
          bi = 3'((mon_cyc - 4) / 4);
          if (mon_cyc < 4)       exp_bit = 1'b0;
          else if (mon_cyc < 36) exp_bit = head[bi];
          else                   exp_bit = 1'b1;
          if (bus.txOut !== exp_bit) shape_ok = 1'b0;
          if (mon_cyc >= 4 && mon_cyc < 36 && ((mon_cyc - 4) % 4) == 2) rx_byte[bi] = bus.txOut;
          if (mon_cyc == 39) begin
            if (has_head) begin
              void'(exp_q.pop_front());
              check("frame_byte", 32'(rx_byte), 32'(head));
              check("frame_shape", 32'(shape_ok), 32'd1);
            end
            $display("frame received byte=%02h", rx_byte);
            frames_seen++;
            mon_active = 1'b0;
            gap        = 0;
            gap_valid  = 1'b1;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n_busy;
    int f0;
    int k;
    bit seen;

    bus.keyByte  = 8'h00;
    bus.keyReady = 1'b0;

    // 1: reset with keyReady pulsing
    bus.keyByte  = 8'hC3;
    bus.keyReady = 1'b1;
    @(posedge clk); #1; bus.keyReady = 1'b0;
    @(posedge clk); #1; bus.keyReady = 1'b1;
    @(posedge clk); #1; bus.keyReady = 1'b0;
    RST = 1'b0;
    check("reset_txOut", 32'(bus.txOut), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.busy || !bus.txOut) seen = 1'b1;
    end
    check("reset_no_frame", 32'(seen), 32'd0);
    $display("test1 reset done");

    // 2: single key 0x41, latency and busy width
    send_key(8'h41, 1'b1);
    n_busy = 0;
    for (int j = 1; j <= 200; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        check("latency_txOut_K1", 32'(bus.txOut), 32'd1);
        check("latency_busy_K1", 32'(bus.busy), 32'd1);
      end
      if (j == 2) check("latency_txOut_K2", 32'(bus.txOut), 32'd0);
      if (bus.busy) n_busy++;
      else if (n_busy > 0) break;
    end
    check("busy_cycles", 32'(n_busy), 32'd40);
    wait_drain(200, "single");
    check("single_count_end", 32'(bus.count), 32'd0);
    $display("test2 single key done");

    // 3: burst of 10 keys, 0x0A dropped
    f0 = frames_seen;
    @(posedge clk); #1;
    for (int i = 1; i <= 10; i++) begin
      bus.keyByte  = 8'(i);
      bus.keyReady = 1'b1;
      if (i <= 9) exp_q.push_back(8'(i));
      @(posedge clk); #1;
      if (i == 9) begin
        check("burst_count_peak", 32'(bus.count), 32'd8);
        check("burst_overflow_before", 32'(bus.overflow), 32'd0);
      end
      if (i == 10) begin
        check("burst_count_full", 32'(bus.count), 32'd8);
        check("burst_overflow_after", 32'(bus.overflow), 32'd1);
      end
    end
    bus.keyReady = 1'b0;
    wait_drain(1000, "burst");
    check("burst_frames", 32'(frames_seen - f0), 32'd9);
    check("burst_overflow_sticky", 32'(bus.overflow), 32'd1);
    $display("test3 burst done");

    // 4: full FIFO plus key in the pop cycle
    apply_reset();
    check("rst_clears_overflow", 32'(bus.overflow), 32'd0);
    send_key(8'h10, 1'b1);
    for (int i = 1; i <= 8; i++) send_key(8'(8'h10 + i), 1'b1);
    check("full_count", 32'(bus.count), 32'd8);
    check("full_busy", 32'(bus.busy), 32'd1);
    k = 0;
    while (bus.busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("full_wait_idle_timeout", 32'(k >= 100), 32'd0);
    bus.keyByte  = 8'h55;
    bus.keyReady = 1'b1;
    exp_q.push_back(8'h55);
    @(posedge clk); #1;
    bus.keyReady = 1'b0;
    check("simul_count", 32'(bus.count), 32'd8);
    check("simul_overflow", 32'(bus.overflow), 32'd0);
    check("simul_busy", 32'(bus.busy), 32'd1);
    wait_drain(1000, "simul");
    check("simul_overflow_end", 32'(bus.overflow), 32'd0);
    $display("test4 full plus pop done");

    // 5: reset during data bit 3 of 0xA5
    apply_reset();
    send_key(8'hA5, 1'b1);
    send_key(8'h01, 1'b1);
    send_key(8'h02, 1'b1);
    send_key(8'h03, 1'b1);
    k = 0;
    while (!(mon_active && mon_cyc == 16) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("midframe_reach_bit3", 32'(k >= 100), 32'd0);
    check("midframe_bit3_level", 32'(bus.txOut), 32'd0);
    check("midframe_count_queued", 32'(bus.count), 32'd3);
    RST = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    RST = 1'b0;
    check("midframe_txOut", 32'(bus.txOut), 32'd1);
    check("midframe_count", 32'(bus.count), 32'd0);
    check("midframe_busy", 32'(bus.busy), 32'd0);
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.busy || !bus.txOut) seen = 1'b1;
    end
    check("midframe_quiet", 32'(seen), 32'd0);
    $display("test5 reset mid-frame done");

    // 6: edge data 0x00 then 0xFF back to back
    f0 = frames_seen;
    send_key(8'h00, 1'b1);
    send_key(8'hFF, 1'b1);
    wait_drain(300, "edge");
    check("edge_frames", 32'(frames_seen - f0), 32'd2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test6 edge data done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
